prim_cdc_handshake_tx: RTL and testbench
========================================

# prim_cdc_handshake_tx

Source-domain end of a four-phase req/ack clock-domain-crossing data channel. Accepts a word over a valid/ready interface in the `clk_i` domain and holds it stable on `data_o`. It then drives `req_o` across the boundary and completes the handshake using a synchronized copy of the destination's `ack_i`. The matching receiver sits in the destination domain. `data_o` and `req_o` are flop outputs, safe to cross.

## Interface
Parameters:
- DataWidth, 8, width of transferred word (≥1)
- SyncStages, 2, flops in the `ack_i` synchronizer (≥2)
- TimeoutCycles, 1024, handshake-phase watchdog limit (≥2); used only with the timeout feature compiled in

Ports (reset `rst_ni`, asynchronous, active-low; clock `clk_i`):
- clk_i  in  1  source-domain clock
- rst_ni  in  1  async active-low reset
- valid_i  in  1  word offered on `data_i`
- ready_o  out  1  block can accept; transfer occurs on `valid_i & ready_o` at posedge
- data_i  in  DataWidth  word to send
- req_o  out  DataWidth-independent 1  four-phase request to the destination domain (registered)
- data_o  out  DataWidth  captured word, stable while `req_o`=1 and until the next accept
- ack_i  in  1  four-phase acknowledge from the destination domain (asynchronous to `clk_i`)
- busy_o  out  1  handshake in progress (state ≠ IDLE)
- timeout_o  out  1  sticky watchdog error

## Operation
- `ack_s` = `ack_i` after SyncStages flops, all reset to 0. No logic reads `ack_i` directly.
- FSM states:
  - IDLE
    - `ready_o` = IDLE & ~`ack_s`.
    - On accept: `data_o`<=`data_i`, `req_o`<=1, go to REQ_HI.
  - REQ_HI
    - Hold `req_o`=1.
    - When `ack_s`=1: `req_o`<=0, go to REQ_LO.
  - REQ_LO
    - Hold `req_o`=0.
    - When `ack_s`=0: go to IDLE.
- `ready_o` is combinational from state and `ack_s` only. There is no path from `valid_i` to `ready_o`.
- `busy_o` = (state ≠ IDLE).
- `data_o` changes only on accept. It holds its value through IDLE.
- `valid_i` deasserted while `ready_o`=0 has no effect. Withdrawing `valid_i` is allowed.
- `ack_s`=1 while in IDLE is a stale or illegal ack. `ready_o` stays 0 until `ack_s` falls. No req is issued.
- `ack_s` falling while in REQ_HI is ignored. The FSM waits for `ack_s`=1.
- Reset mid-handshake: the FSM goes to IDLE and `req_o` drops asynchronously. The receiver must tolerate the aborted transfer.

## Timing
- Reset values:
  - `ready_o`=1 (IDLE, `ack_s`=0)
  - `req_o`=0
  - `data_o`=0
  - `busy_o`=0
  - `timeout_o`=0
  - synchronizer flops = 0
- Accept at edge N gives `req_o`=1 and `data_o` valid from N+1 (1-cycle latency).
- `ack_i` rising before edge M gives `ack_s`=1 after edge M+SyncStages-1. `req_o` falls one edge later.
- `ack_i` falling gives IDLE after the same SyncStages+1 edge delay.
- Minimum accept-to-accept period: 2·(SyncStages+1)+1 source cycles, plus destination response time.

## Configuration
- `PRIM_CDC_HANDSHAKE_TX_TIMEOUT_EN` defined:
  - A `$clog2(TimeoutCycles+1)`-bit counter clears on entering REQ_HI or REQ_LO and increments each cycle in those states.
  - When it reaches TimeoutCycles-1, `timeout_o` sets and stays set until reset.
  - The FSM does not abort; it keeps waiting.
  - The counter saturates and does not wrap.
- Macro undefined: no counter is synthesized and `timeout_o` is tied to 0.

## Structure
- `prim_cdc_pkg` holds:
  - `cdc_tx_state_e` (IDLE, REQ_HI, REQ_LO), 2-bit enum
  - the default SyncStages constant, shared with the receiver
- Sub-module `prim_cdc_sync_bit`: parameterized SyncStages flop chain with async reset value 0. It is reused by the receiver for `req_i`.

## Test plan
- After reset: outputs are ready_o=1, req_o=0, data_o=0x00, busy_o=0.
  - Then `valid_i`=1, `data_i`=0xA5 at edge 3: req_o=1 and data_o=0xA5 at edge 4, ready_o=0.
- Full handshake, SyncStages=2, with a BFM that raises `ack_i` 3 cycles after seeing `req_o` and drops it 3 cycles after `req_o` falls:
  - `req_o` falls exactly 2 edges after ack sampling.
  - IDLE is reached and `ready_o`=1.
  - `data_o` stays 0xA5 throughout.
- Back-to-back burst 0x01..0x10 with `valid_i` held high: the receiver model collects 16 words in order with no duplicates. `data_o` never changes while `req_o`=1.
- `ack_i` forced to 1 in IDLE: `ready_o`=0 and `req_o` stays 0 under `valid_i`=1. Releasing `ack_i` makes `ready_o`=1 after 2 edges.
- Assert `rst_ni` low while in REQ_HI: `req_o`=0 and busy_o=0 immediately. After release, a new transfer of 0x3C completes.
- With `PRIM_CDC_HANDSHAKE_TX_TIMEOUT_EN` and TimeoutCycles=16, with `ack_i` stuck at 0: `timeout_o` rises 16 cycles after entering REQ_HI, and `req_o` stays 1. Without the macro, `timeout_o` stays 0.

Source files
------------

// File: rtl/prim_cdc_pkg.sv
// Shared definitions for the four-phase req/ack CDC handshake pair (transmitter and receiver).
// The transmitter's optional watchdog is enabled by PRIM_CDC_HANDSHAKE_TX_TIMEOUT_EN.
package prim_cdc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } cdc_tx_state_e;

    localparam int unsigned CdcSyncStagesDefault = 32'd2;

    // True while a handshake phase is outstanding (req high or waiting for ack release).
    function automatic logic cdc_tx_in_handshake(input cdc_tx_state_e state);
        return (state == REQ_HI) || (state == REQ_LO);
    endfunction

endpackage

// File: rtl/prim_cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous clear to 0.
// Shared by the handshake transmitter (ack) and receiver (req).
module prim_cdc_sync_bit #(
    parameter int unsigned SyncStages = 32'd2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SyncStages-1:0] sync_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_r <= {SyncStages{1'b0}};
        end else begin
            sync_r <= {sync_r[SyncStages-2:0], d_i};
        end
    end

    assign q_o = sync_r[SyncStages-1];

endmodule

// File: rtl/prim_cdc_handshake_tx.sv
// Source-domain end of a four-phase req/ack CDC data channel.
// Optional sticky handshake watchdog: define PRIM_CDC_HANDSHAKE_TX_TIMEOUT_EN.
module prim_cdc_handshake_tx
    import prim_cdc_pkg::*;
#(
    parameter int unsigned DataWidth     = 32'd8,
    parameter int unsigned SyncStages    = CdcSyncStagesDefault,
    parameter int unsigned TimeoutCycles = 32'd1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 req_o,
    output logic [DataWidth-1:0] data_o,
    input  logic                 ack_i,
    output logic                 busy_o,
    output logic                 timeout_o
);

    cdc_tx_state_e        state_r;
    logic                 req_r;
    logic                 busy_r;
    logic [DataWidth-1:0] data_r;
    logic                 ack_s;
    logic                 accept_s;

    prim_cdc_sync_bit #(
        .SyncStages (SyncStages)
    ) u_ack_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (ack_i),
        .q_o    (ack_s)
    );

    // A stale ack seen in IDLE blocks new requests until it is released.
    assign ready_o  = (state_r == IDLE) & ~ack_s;
    assign accept_s = valid_i & ready_o;

    // Handshake FSM; req, busy and the captured word are registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            busy_r  <= 1'b0;
            data_r  <= {DataWidth{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        data_r  <= data_i;
                        req_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        req_r   <= 1'b0;
                        state_r <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    req_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_o  = req_r;
    assign busy_o = busy_r;
    assign data_o = data_r;

`ifdef PRIM_CDC_HANDSHAKE_TX_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 32'd1);
    localparam logic [CntW-1:0] CntMax   = CntW'(TimeoutCycles);
    localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles - 32'd1);

    logic [CntW-1:0] cnt_r;
    logic            timeout_r;
    logic            phase_enter_s;

    // A new phase starts on accept (into REQ_HI) or on ack rising (into REQ_LO).
    always_comb begin
        phase_enter_s = 1'b0;
        if (state_r == IDLE) begin
            phase_enter_s = accept_s;
        end else if (state_r == REQ_HI) begin
            phase_enter_s = ack_s;
        end else begin
            phase_enter_s = 1'b0;
        end
    end

    // Per-phase saturating counter and sticky error flag; the FSM keeps waiting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r     <= {CntW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            if (phase_enter_s) begin
                cnt_r <= {CntW{1'b0}};
            end else if (cdc_tx_in_handshake(state_r) && (cnt_r != CntMax)) begin
                cnt_r <= cnt_r + {{(CntW-1){1'b0}}, 1'b1};
            end
            if (cdc_tx_in_handshake(state_r) && (cnt_r >= CntLimit)) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_r;
`else
    logic unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = (TimeoutCycles > 32'd1);
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_cdc_handshake_tx.sv
// Self-checking bench for prim_cdc_handshake_tx: vector table, directed corner cases,
// and a randomized run against a transaction-level reference model.
module tb_prim_cdc_handshake_tx;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data_i = '0;
    logic          req_o;
    logic [DW-1:0] data_o;
    logic          ack_i;
    logic          busy_o;
    logic          timeout_o;

    logic   ack_man = 1'b0;
    logic   ack_bfm = 1'b0;
    logic   bfm_en = 1'b0;
    logic   bfm_rand = 1'b0;
    int     bfm_dly = 3;
    int     bcnt = 0;
    logic [DW-1:0] rx_q[$];

    int n_cmp = 0;
    int n_err = 0;

    assign ack_i = bfm_en ? ack_bfm : ack_man;

    prim_cdc_handshake_tx #(
        .DataWidth     (DW),
        .SyncStages    (SS),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .req_o     (req_o),
        .data_o    (data_o),
        .ack_i     (ack_i),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          ack;
        logic          ready;
        logic          req;
        logic          busy;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_o && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_idle_reached"}, {31'd0, busy_o}, 32'd0);
    endtask

    // Receiver BFM: raises ack bfm_dly cycles after seeing req, drops it after req falls.
    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            if (!bfm_en) begin
                ack_bfm = 1'b0;
                bcnt = 0;
            end else if (req_o && !ack_bfm) begin
                bcnt++;
                if (bcnt >= bfm_dly) begin
                    ack_bfm = 1'b1;
                    rx_q.push_back(data_o);
                    bcnt = 0;
                    bfm_dly = bfm_rand ? int'($urandom_range(1, 5)) : 3;
                end
            end else if (!req_o && ack_bfm) begin
                bcnt++;
                if (bcnt >= bfm_dly) begin
                    ack_bfm = 1'b0;
                    bcnt = 0;
                    bfm_dly = bfm_rand ? int'($urandom_range(1, 5)) : 3;
                end
            end else begin
                bcnt = 0;
            end
        end
    end

    // One complete transfer through the BFM, checking ack-to-req-fall latency and data stability.
    task automatic xfer(input logic [DW-1:0] d);
        int n;
        int t;
        int t_ack;
        int t_fall;
        logic acc;
        valid_i = 1'b1;
        data_i  = d;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            acc = ready_o;
            tick();
            n++;
        end
        valid_i = 1'b0;
        chk("xfer_accept", {31'd0, acc}, 32'd1);
        chk("xfer_req_rise", {31'd0, req_o}, 32'd1);
        t = 0;
        t_ack = -1;
        t_fall = -1;
        while (busy_o && t < 100) begin
            tick();
            t++;
            if (ack_i && t_ack < 0) t_ack = t;
            if (t_ack >= 0 && !req_o && t_fall < 0) t_fall = t;
            if (req_o) chk("xfer_data_stable", {24'd0, data_o}, {24'd0, d});
        end
        chk("xfer_req_fall_latency", t_fall - t_ack, SS);
        chk("xfer_idle", {31'd0, busy_o}, 32'd0);
        chk("xfer_ready_after", {31'd0, ready_o}, 32'd1);
        chk("xfer_data_hold", {24'd0, data_o}, {24'd0, d});
        chk("xfer_rx_word", {24'd0, rx_q[rx_q.size()-1]}, {24'd0, d});
    endtask

    // Reference model: ack history line plus "word outstanding" / "awaiting ack release" flags.
    logic          hist[SS];
    bit            m_pend;
    bit            m_drain;
    logic [DW-1:0] m_word;

    initial begin
        logic [DW-1:0] cur;
        logic [DW-1:0] last;
        logic          acc;
        logic          acks;
        int            n;

        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[1] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[5] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        tbl[8] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A};

        #1 rst_ni = 1'b0;
        #2;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_req", {31'd0, req_o}, 32'd0);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        #19 rst_ni = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            valid_i = tbl[i].valid;
            data_i  = tbl[i].data;
            ack_man = tbl[i].ack;
            tick();
            chk($sformatf("vec%0d_ready", i), {31'd0, ready_o}, {31'd0, tbl[i].ready});
            chk($sformatf("vec%0d_req", i), {31'd0, req_o}, {31'd0, tbl[i].req});
            chk($sformatf("vec%0d_busy", i), {31'd0, busy_o}, {31'd0, tbl[i].busy});
            chk($sformatf("vec%0d_data", i), {24'd0, data_o}, {24'd0, tbl[i].dout});
            chk($sformatf("vec%0d_timeout", i), {31'd0, timeout_o}, 32'd0);
        end
        valid_i = 1'b0;
        bfm_en = 1'b1;
        wait_idle("vec_tail");
        bfm_en = 1'b0;
        tick();

        // Stale ack in IDLE blocks requests until released.
        ack_man = 1'b1;
        repeat (3) tick();
        valid_i = 1'b1;
        data_i  = 8'h77;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stale_ready", {31'd0, ready_o}, 32'd0);
            chk("stale_req", {31'd0, req_o}, 32'd0);
        end
        valid_i = 1'b0;
        ack_man = 1'b0;
        tick();
        chk("stale_release_1", {31'd0, ready_o}, 32'd0);
        tick();
        chk("stale_release_2", {31'd0, ready_o}, 32'd1);

        // Reset while in REQ_HI drops req immediately.
        valid_i = 1'b1;
        data_i  = 8'h99;
        tick();
        valid_i = 1'b0;
        chk("abort_req_hi", {31'd0, req_o}, 32'd1);
        #3 rst_ni = 1'b0;
        #1;
        chk("abort_req", {31'd0, req_o}, 32'd0);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        #2 rst_ni = 1'b1;
        tick();

        bfm_en = 1'b1;
        bfm_dly = 3;
        rx_q.delete();
        xfer(8'h3C);

        // Back-to-back burst with valid held high.
        rx_q.delete();
        cur = 8'h01;
        last = 8'h3C;
        n = 0;
        valid_i = 1'b1;
        while (cur <= 8'h10 && n < 2000) begin
            data_i = cur;
            acc = ready_o;
            tick();
            n++;
            if (acc) begin
                last = cur;
                cur = cur + 8'h01;
            end
            if (req_o) chk("burst_data_stable", {24'd0, data_o}, {24'd0, last});
        end
        valid_i = 1'b0;
        wait_idle("burst");
        chk("burst_count", rx_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < rx_q.size()) chk($sformatf("burst_word%0d", i), {24'd0, rx_q[i]}, i + 1);
        end

        // Randomized traffic against the reference model.
        bfm_rand = 1'b1;
        for (int i = 0; i < SS; i++) hist[i] = 1'b0;
        m_pend = 1'b0;
        m_drain = 1'b0;
        m_word = last;
        for (int c = 0; c < 400; c++) begin
            valid_i = ($urandom_range(0, 2) != 0);
            data_i  = DW'($urandom);
            acc = valid_i;
            cur = data_i;
            tick();
            acks = hist[SS-1];
            if (!m_pend && !m_drain) begin
                if (acc && !acks) begin
                    m_pend = 1'b1;
                    m_word = cur;
                end
            end else if (m_pend) begin
                if (acks) begin
                    m_pend = 1'b0;
                    m_drain = 1'b1;
                end
            end else begin
                if (!acks) m_drain = 1'b0;
            end
            for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = ack_i;
            chk("rnd_req", {31'd0, req_o}, {31'd0, m_pend});
            chk("rnd_busy", {31'd0, busy_o}, {31'd0, m_pend | m_drain});
            chk("rnd_ready", {31'd0, ready_o}, {31'd0, !m_pend && !m_drain && !hist[SS-1]});
            chk("rnd_data", {24'd0, data_o}, {24'd0, m_word});
            chk("rnd_timeout", {31'd0, timeout_o}, 32'd0);
        end
        valid_i = 1'b0;
        bfm_rand = 1'b0;
        wait_idle("rnd");
        repeat (3) tick();
        bfm_en = 1'b0;
        ack_man = 1'b0;
        repeat (3) tick();

        // Watchdog with ack stuck low.
        chk("to_ready", {31'd0, ready_o}, 32'd1);
        valid_i = 1'b1;
        data_i  = 8'hC3;
        tick();
        valid_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef PRIM_CDC_HANDSHAKE_TX_TIMEOUT_EN
            chk($sformatf("to_flag_k%0d", k), {31'd0, timeout_o}, {31'd0, k >= TO});
`else
            chk($sformatf("to_flag_k%0d", k), {31'd0, timeout_o}, 32'd0);
`endif
            chk("to_req_held", {31'd0, req_o}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
